// File: rtl/p_bus_pkg.sv
// Shared types and helpers for the parallel peripheral bus decoder and
// related interconnect blocks.
package p_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_RELEASE,
    ST_RESPOND,
    ST_WAIT
  } dec_state_t;

  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_HALF  = 3'd1;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;
  localparam logic [2:0] SIZE_QUAD  = 3'd4;

  // Only the low address bits can affect natural alignment for any legal size.
  function automatic logic size_aligned(input logic [7:0] addr_lo, input logic [2:0] size);
    logic [7:0] lsb_mask;
    lsb_mask = (8'd1 << size) - 8'd1;
    return (addr_lo & lsb_mask) == 8'd0;
  endfunction

endpackage

// File: rtl/p_bus_addr_match.sv
// Combinational priority address matcher: lowest-index window that matches
// (addr & mask) == base wins.
module p_bus_addr_match #(
  parameter int unsigned                  XLEN        = 32,
  parameter int unsigned                  TARGETS     = 4,
  parameter int unsigned                  SEL_W       = (TARGETS > 1) ? $clog2(TARGETS) : 1,
  parameter logic [TARGETS*XLEN-1:0]      TARGET_BASE = '0,
  parameter logic [TARGETS*XLEN-1:0]      TARGET_MASK = '0
) (
  input  logic [XLEN-1:0]  addr,
  output logic             hit,
  output logic [SEL_W-1:0] sel
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int unsigned i = TARGETS; i > 0; i--) begin
      if ((addr & TARGET_MASK[(i-1)*XLEN +: XLEN]) == TARGET_BASE[(i-1)*XLEN +: XLEN]) begin
        hit = 1'b1;
        sel = SEL_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/p_bus_decoder.sv
// Single-initiator, multi-target address decoder: forwards one request to the
// window-selected target and answers unmapped/illegal/stalled requests locally.
module p_bus_decoder
  import p_bus_pkg::*;
#(
  parameter int unsigned             XLEN        = 32,
  parameter int unsigned             TARGETS     = 4,
  parameter logic [TARGETS*XLEN-1:0] TARGET_BASE = '0,
  parameter logic [TARGETS*XLEN-1:0] TARGET_MASK = '0,
  parameter int unsigned             TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    bus_valid,
  input  logic                    bus_rw,
  input  logic [XLEN-1:0]         bus_addr,
  input  logic [XLEN-1:0]         bus_wdata,
  input  logic [XLEN/8-1:0]       bus_wstrb,
  input  logic [2:0]              bus_size,
  output logic                    bus_ready,
  output logic [XLEN-1:0]         bus_rdata,
  output logic                    bus_denied,
  output logic                    bus_corrupt,

  output logic [TARGETS-1:0]      t_valid,
  output logic                    t_rw,
  output logic [XLEN-1:0]         t_addr,
  output logic [XLEN-1:0]         t_wdata,
  output logic [XLEN/8-1:0]       t_wstrb,
  output logic [2:0]              t_size,
  input  logic [TARGETS-1:0]      t_ready,
  input  logic [TARGETS*XLEN-1:0] t_rdata,
  input  logic [TARGETS-1:0]      t_denied,
  input  logic [TARGETS-1:0]      t_corrupt
);

  localparam int unsigned SEL_W    = (TARGETS > 1) ? $clog2(TARGETS) : 1;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [2:0]  MAX_SIZE = 3'($clog2(XLEN / 8));

  if (!(XLEN == 32 || XLEN == 64)) begin : g_xlen_check
    $error("p_bus_decoder: XLEN must be 32 or 64");
  end
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("p_bus_decoder: TIMEOUT must be at least 2");
  end

  dec_state_t          state_q, state_d;
  logic                req_rw_q, req_rw_d;
  logic [XLEN-1:0]     req_addr_q, req_addr_d;
  logic [XLEN-1:0]     req_wdata_q, req_wdata_d;
  logic [XLEN/8-1:0]   req_wstrb_q, req_wstrb_d;
  logic [2:0]          req_size_q, req_size_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TARGETS-1:0]  t_valid_q, t_valid_d;
  logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
  logic                resp_denied_q, resp_denied_d;
  logic                resp_corrupt_q, resp_corrupt_d;
  logic                bus_ready_q, bus_ready_d;
  logic [XLEN-1:0]     bus_rdata_q, bus_rdata_d;
  logic                bus_denied_q, bus_denied_d;
  logic                bus_corrupt_q, bus_corrupt_d;

  logic                match_hit;
  logic [SEL_W-1:0]    match_sel;
  logic                req_legal;

  p_bus_addr_match #(
    .XLEN        (XLEN),
    .TARGETS     (TARGETS),
    .SEL_W       (SEL_W),
    .TARGET_BASE (TARGET_BASE),
    .TARGET_MASK (TARGET_MASK)
  ) u_addr_match (
    .addr (bus_addr),
    .hit  (match_hit),
    .sel  (match_sel)
  );

  assign req_legal = match_hit && (bus_size <= MAX_SIZE) && size_aligned(bus_addr[7:0], bus_size);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      req_rw_q       <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_wstrb_q    <= '0;
      req_size_q     <= '0;
      sel_q          <= '0;
      cnt_q          <= '0;
      t_valid_q      <= '0;
      resp_rdata_q   <= '0;
      resp_denied_q  <= 1'b0;
      resp_corrupt_q <= 1'b0;
      bus_ready_q    <= 1'b0;
      bus_rdata_q    <= '0;
      bus_denied_q   <= 1'b0;
      bus_corrupt_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_rw_q       <= req_rw_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_wstrb_q    <= req_wstrb_d;
      req_size_q     <= req_size_d;
      sel_q          <= sel_d;
      cnt_q          <= cnt_d;
      t_valid_q      <= t_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_denied_q  <= resp_denied_d;
      resp_corrupt_q <= resp_corrupt_d;
      bus_ready_q    <= bus_ready_d;
      bus_rdata_q    <= bus_rdata_d;
      bus_denied_q   <= bus_denied_d;
      bus_corrupt_q  <= bus_corrupt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_rw_d       = req_rw_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_wstrb_d    = req_wstrb_q;
    req_size_d     = req_size_q;
    sel_d          = sel_q;
    cnt_d          = cnt_q;
    t_valid_d      = t_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_denied_d  = resp_denied_q;
    resp_corrupt_d = resp_corrupt_q;
    bus_ready_d    = 1'b0;
    bus_rdata_d    = bus_rdata_q;
    bus_denied_d   = bus_denied_q;
    bus_corrupt_d  = bus_corrupt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus_valid) begin
          req_rw_d    = bus_rw;
          req_addr_d  = bus_addr;
          req_wdata_d = bus_wdata;
          req_wstrb_d = bus_wstrb;
          req_size_d  = bus_size;
          cnt_d       = '0;
          if (req_legal) begin
            sel_d   = match_sel;
            state_d = ST_DRIVE;
          end else begin
            resp_rdata_d   = '0;
            resp_denied_d  = 1'b1;
            resp_corrupt_d = 1'b0;
            state_d        = ST_RESPOND;
          end
        end
      end

      // t_valid is registered, so ready is only honoured once the target
      // has actually seen valid; a ready on the same edge as the timeout wins.
      ST_DRIVE: begin
        t_valid_d        = '0;
        t_valid_d[sel_q] = 1'b1;
        if (t_valid_q[sel_q] && t_ready[sel_q]) begin
          resp_rdata_d   = t_rdata[sel_q*XLEN +: XLEN];
          resp_denied_d  = t_denied[sel_q];
          resp_corrupt_d = t_corrupt[sel_q];
          t_valid_d      = '0;
          state_d        = ST_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          resp_rdata_d   = '0;
          resp_denied_d  = 1'b1;
          resp_corrupt_d = 1'b1;
          t_valid_d      = '0;
          state_d        = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        state_d = ST_RESPOND;
      end

      ST_RESPOND: begin
        bus_ready_d   = 1'b1;
        bus_rdata_d   = resp_rdata_q;
        bus_denied_d  = resp_denied_q;
        bus_corrupt_d = resp_corrupt_q;
        state_d       = ST_WAIT;
      end

      ST_WAIT: begin
        if (!bus_valid) begin
          bus_rdata_d   = '0;
          bus_denied_d  = 1'b0;
          bus_corrupt_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic t_active;
  assign t_active = |t_valid_q;

  assign t_valid     = t_valid_q;
  assign t_rw        = t_active & req_rw_q;
  assign t_addr      = t_active ? req_addr_q  : '0;
  assign t_wdata     = t_active ? req_wdata_q : '0;
  assign t_wstrb     = t_active ? req_wstrb_q : '0;
  assign t_size      = t_active ? req_size_q  : '0;

  assign bus_ready   = bus_ready_q;
  assign bus_rdata   = bus_rdata_q;
  assign bus_denied  = bus_denied_q;
  assign bus_corrupt = bus_corrupt_q;

endmodule

// File: tb/tb_p_bus_decoder.sv
// Directed-vector bench for p_bus_decoder with two 4 KiB target windows.
module tb_p_bus_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_valid, bus_rw;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [2:0]  bus_size;
  logic        bus_ready, bus_denied, bus_corrupt;
  logic [31:0] bus_rdata;
  logic [1:0]  t_valid;
  logic        t_rw;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_wstrb;
  logic [2:0]  t_size;
  logic [1:0]  t_ready, t_denied, t_corrupt;
  logic [63:0] t_rdata;

  int n_vec = 0;
  int n_err = 0;

  p_bus_decoder #(
    .XLEN        (32),
    .TARGETS     (2),
    .TARGET_BASE ({32'h1000_1000, 32'h1000_0000}),
    .TARGET_MASK ({32'hFFFF_F000, 32'hFFFF_F000}),
    .TIMEOUT     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_valid   (bus_valid),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_size    (bus_size),
    .bus_ready   (bus_ready),
    .bus_rdata   (bus_rdata),
    .bus_denied  (bus_denied),
    .bus_corrupt (bus_corrupt),
    .t_valid     (t_valid),
    .t_rw        (t_rw),
    .t_addr      (t_addr),
    .t_wdata     (t_wdata),
    .t_wstrb     (t_wstrb),
    .t_size      (t_size),
    .t_ready     (t_ready),
    .t_rdata     (t_rdata),
    .t_denied    (t_denied),
    .t_corrupt   (t_corrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observations of the most recent transaction; k counts negedges after the
  // request was presented, so k=1 follows the sampling edge.
  logic [1:0]  obs_tvmask;
  int          obs_tv_cycles, obs_first_tv_k, obs_raise_k, obs_br_k, obs_br_cycles;
  logic        obs_leak, obs_t_rw;
  logic [31:0] obs_t_addr, obs_t_wdata, obs_rdata, obs_held_rdata, obs_after_rdata;
  logic [3:0]  obs_t_wstrb;
  logic [2:0]  obs_t_size;
  logic        obs_den, obs_cor, obs_held_den, obs_after_den, obs_after_cor;

  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] size,
                         input int rdy_tgt, input int rdy_delay, input logic [31:0] rdata,
                         input logic tden, input logic tcor, input int inject_k);
    int   wait_cnt;
    logic responded, pend, done;
    obs_tvmask = '0; obs_tv_cycles = 0; obs_first_tv_k = 0; obs_raise_k = 0;
    obs_br_k = 0; obs_br_cycles = 0; obs_leak = 1'b0;
    obs_t_rw = 1'b0; obs_t_addr = '0; obs_t_wdata = '0; obs_t_wstrb = '0; obs_t_size = '0;
    obs_rdata = '0; obs_den = 1'b0; obs_cor = 1'b0;
    obs_held_rdata = '0; obs_held_den = 1'b0;
    obs_after_rdata = 32'hFFFF_FFFF; obs_after_den = 1'b1; obs_after_cor = 1'b1;
    wait_cnt = 0; responded = 1'b0; pend = 1'b0; done = 1'b0;

    @(negedge clk);
    bus_valid = 1'b1; bus_rw = rw; bus_addr = addr; bus_wdata = wdata;
    bus_wstrb = wstrb; bus_size = size;

    for (int k = 1; k <= 80 && !done; k++) begin
      @(negedge clk);
      if (pend) begin
        t_ready = '0; t_rdata = '0; t_denied = '0; t_corrupt = '0; pend = 1'b0;
      end
      if (t_valid != 2'b00) begin
        if (obs_first_tv_k == 0) begin
          obs_first_tv_k = k; obs_t_rw = t_rw; obs_t_addr = t_addr;
          obs_t_wdata = t_wdata; obs_t_wstrb = t_wstrb; obs_t_size = t_size;
        end
        obs_tvmask = obs_tvmask | t_valid;
        obs_tv_cycles++;
      end else if ({t_rw, t_addr, t_wdata, t_wstrb, t_size} != '0) begin
        obs_leak = 1'b1;
      end
      if (bus_ready) begin
        obs_br_cycles++;
        if (obs_br_k == 0) begin
          obs_br_k = k; obs_rdata = bus_rdata; obs_den = bus_denied; obs_cor = bus_corrupt;
        end
      end
      if (rdy_tgt < 2 && !responded && t_valid[rdy_tgt]) begin
        if (wait_cnt == rdy_delay) begin
          t_ready[rdy_tgt] = 1'b1;
          t_rdata[rdy_tgt*32 +: 32] = rdata;
          t_denied[rdy_tgt] = tden;
          t_corrupt[rdy_tgt] = tcor;
          responded = 1'b1; pend = 1'b1; obs_raise_k = k;
        end else begin
          wait_cnt++;
        end
      end
      if (inject_k != 0 && k == inject_k) begin
        t_ready[0] = 1'b1; t_rdata[31:0] = 32'hBAD0_BAD0; pend = 1'b1;
      end
      if (obs_br_k != 0 && k == obs_br_k + 1) begin
        obs_held_rdata = bus_rdata; obs_held_den = bus_denied;
        bus_valid = 1'b0;
      end
      if (obs_br_k != 0 && k == obs_br_k + 2) begin
        obs_after_rdata = bus_rdata; obs_after_den = bus_denied; obs_after_cor = bus_corrupt;
        done = 1'b1;
      end
    end
    if (!done) begin
      bus_valid = 1'b0; t_ready = '0; t_rdata = '0; t_denied = '0; t_corrupt = '0;
      chk("txn_complete", 64'(done), 64'd1);
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic chk_release(input string tag);
    chk({tag, "_br_width"}, 64'(obs_br_cycles), 64'd1);
    chk({tag, "_after_rdata"}, 64'(obs_after_rdata), 64'd0);
    chk({tag, "_after_flags"}, {62'd0, obs_after_den, obs_after_cor}, 64'd0);
    chk({tag, "_no_leak"}, 64'(obs_leak), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus_valid = 1'b0; bus_rw = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wstrb = '0; bus_size = '0;
    t_ready = '0; t_rdata = '0; t_denied = '0; t_corrupt = '0;
    repeat (2) @(negedge clk);
    chk("reset_tvalid", 64'(t_valid), 64'd0);
    chk("reset_bus_out", {31'd0, bus_ready, bus_rdata}, 64'd0);
    chk("reset_flags", {62'd0, bus_denied, bus_corrupt}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Word write to target 1, immediate ready.
    run_txn(1'b0, 32'h1000_1004, 32'hA5A5_A5A5, 4'hF, 3'd2, 1, 0, 32'h0, 1'b0, 1'b0, 0);
    chk("wr_tvmask", 64'(obs_tvmask), 64'h2);
    chk("wr_first_tv", 64'(obs_first_tv_k), 64'd2);
    chk("wr_taddr", 64'(obs_t_addr), 64'h1000_1004);
    chk("wr_twdata", 64'(obs_t_wdata), 64'hA5A5_A5A5);
    chk("wr_tctrl", {56'd0, obs_t_rw, obs_t_wstrb, obs_t_size}, {56'd0, 1'b0, 4'hF, 3'd2});
    chk("wr_tv_cycles", 64'(obs_tv_cycles), 64'd1);
    chk("wr_br_lat", 64'(obs_br_k - obs_raise_k), 64'd3);
    chk("wr_flags", {62'd0, obs_den, obs_cor}, 64'd0);
    chk_release("wr");

    // Byte read from target 0 after two wait cycles.
    run_txn(1'b1, 32'h1000_0002, 32'h0, 4'h0, 3'd0, 0, 2, 32'h0000_0055, 1'b0, 1'b0, 0);
    chk("rd_tvmask", 64'(obs_tvmask), 64'h1);
    chk("rd_trw_size", {60'd0, obs_t_rw, obs_t_size}, {60'd0, 1'b1, 3'd0});
    chk("rd_tv_cycles", 64'(obs_tv_cycles), 64'd3);
    chk("rd_br_k", 64'(obs_br_k), 64'd7);
    chk("rd_rdata", 64'(obs_rdata), 64'h55);
    chk("rd_held_rdata", 64'(obs_held_rdata), 64'h55);
    chk("rd_flags", {62'd0, obs_den, obs_cor}, 64'd0);
    chk_release("rd");

    // Unmapped read.
    run_txn(1'b1, 32'h2000_0000, 32'h0, 4'h0, 3'd2, 2, 0, 32'h0, 1'b0, 1'b0, 0);
    chk("unmap_tvmask", 64'(obs_tvmask), 64'h0);
    chk("unmap_br_k", 64'(obs_br_k), 64'd2);
    chk("unmap_flags", {62'd0, obs_den, obs_cor}, 64'h2);
    chk("unmap_rdata", 64'(obs_rdata), 64'd0);
    chk("unmap_held_den", 64'(obs_held_den), 64'd1);
    chk_release("unmap");

    // Misaligned halfword write.
    run_txn(1'b0, 32'h1000_0001, 32'h1234, 4'h3, 3'd1, 0, 0, 32'h0, 1'b0, 1'b0, 0);
    chk("misal_tvmask", 64'(obs_tvmask), 64'h0);
    chk("misal_br_k", 64'(obs_br_k), 64'd2);
    chk("misal_flags", {62'd0, obs_den, obs_cor}, 64'h2);

    // Size 3 is wider than a 32-bit bus.
    run_txn(1'b1, 32'h1000_0000, 32'h0, 4'h0, 3'd3, 0, 0, 32'h0, 1'b0, 1'b0, 0);
    chk("oversize_tvmask", 64'(obs_tvmask), 64'h0);
    chk("oversize_flags", {62'd0, obs_den, obs_cor}, 64'h2);

    // Target 0 never answers; a stray ready lands in RELEASE (k=18).
    run_txn(1'b1, 32'h1000_0010, 32'h0, 4'h0, 3'd2, 2, 0, 32'h0, 1'b0, 1'b0, 18);
    chk("to_tvmask", 64'(obs_tvmask), 64'h1);
    chk("to_tv_cycles", 64'(obs_tv_cycles), 64'd16);
    chk("to_br_k", 64'(obs_br_k), 64'd20);
    chk("to_flags", {62'd0, obs_den, obs_cor}, 64'h3);
    chk("to_rdata", 64'(obs_rdata), 64'd0);
    chk_release("to");

    // Target-reported error propagates with its data.
    run_txn(1'b1, 32'h1000_1ffc, 32'h0, 4'h0, 3'd2, 1, 1, 32'h0000_1234, 1'b1, 1'b0, 0);
    chk("terr_tvmask", 64'(obs_tvmask), 64'h2);
    chk("terr_rdata", 64'(obs_rdata), 64'h1234);
    chk("terr_flags", {62'd0, obs_den, obs_cor}, 64'h2);

    // Asynchronous reset while driving target 1.
    @(negedge clk);
    bus_valid = 1'b1; bus_rw = 1'b1; bus_addr = 32'h1000_1000; bus_size = 3'd2; bus_wstrb = '0;
    for (int k = 0; k < 10 && t_valid == 2'b00; k++) @(negedge clk);
    chk("rst_pre_tvalid", 64'(t_valid), 64'h2);
    #2 reset = 1'b0;
    #1;
    chk("rst_tvalid", 64'(t_valid), 64'd0);
    chk("rst_tfields", {23'd0, t_rw, t_addr, t_wstrb, t_size} | 64'(t_wdata), 64'd0);
    chk("rst_bus_out", {29'd0, bus_ready, bus_denied, bus_corrupt, bus_rdata}, 64'd0);
    @(negedge clk);
    bus_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 32'h1000_1008, 32'h0, 4'h0, 3'd2, 1, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    chk("post_rst_tvmask", 64'(obs_tvmask), 64'h2);
    chk("post_rst_first_tv", 64'(obs_first_tv_k), 64'd2);
    chk("post_rst_rdata", 64'(obs_rdata), 64'hDEAD_BEEF);
    chk("post_rst_br_lat", 64'(obs_br_k - obs_raise_k), 64'd3);
    chk("post_rst_flags", {62'd0, obs_den, obs_cor}, 64'd0);
    chk_release("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/p_bus_decoder.md
# p_bus_decoder

Single-initiator, multi-target address decoder for the parallel peripheral bus. It sits directly upstream of the MMIO peripherals (output register, input register, etc.). It takes one request from the core-side bus, selects a target by address window, and replays the request on that target's valid line. It returns the target's response using the same valid/ready handshake. Unmapped, misaligned or oversized requests and unresponsive targets are answered locally with `denied`.

## Interface
- `XLEN`, 32, bus data/address width; only 32 or 64 are legal, checked by an initial assertion.
- `TARGETS`, 4, number of downstream targets.
- `TARGET_BASE`, all zero, packed `TARGETS*XLEN` array of window base addresses.
- `TARGET_MASK`, all zero, packed `TARGETS*XLEN` array of window masks. A target matches when `(addr & mask) == base`.
- `TIMEOUT`, 255, maximum number of cycles to wait for a target `ready`; must be ≥ 2.
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `bus_valid`, `bus_rw`, `bus_addr[XLEN]`, `bus_wdata[XLEN]`, `bus_wstrb[XLEN/8]`, `bus_size[3]` in: initiator request; `bus_rw`=1 means read.
- `bus_ready`, `bus_rdata[XLEN]`, `bus_denied`, `bus_corrupt` out: response to the initiator.
- `t_valid` out `TARGETS`: one-hot request valid, one bit per target.
- `t_rw`, `t_addr[XLEN]`, `t_wdata[XLEN]`, `t_wstrb[XLEN/8]`, `t_size[3]` out: request fields broadcast to all targets.
- `t_ready` in `TARGETS`: per-target ready.
- `t_rdata` in `TARGETS*XLEN`: per-target read data.
- `t_denied`, `t_corrupt` in `TARGETS`: per-target response flags.

## Operation
- The bus protocol is the same on both sides:
  - The initiator holds valid and all request fields until it sees ready.
  - Ready is a 1-cycle pulse.
  - Response fields are held until valid drops.
  - The responder returns to idle one cycle after valid drops.
- FSM states are IDLE, DRIVE, RELEASE, RESPOND, WAIT.
- **IDLE:** when `bus_valid` is high, latch all request fields and decode.
  - Match: the lowest-index matching target wins. Set `sel`, then go to DRIVE.
  - Reject and go to RESPOND with denied=1, corrupt=0, rdata=0, when any of these holds:
    - no target matches;
    - `bus_size` > log2(XLEN/8);
    - the address is misaligned, i.e. `bus_addr & ((1<<bus_size)-1)` ≠ 0.
- **DRIVE:** `t_valid[sel]`=1 and the `t_*` fields carry the latched request. The timeout counter increments every cycle.
  - On `t_ready[sel]`: capture `t_rdata`/`t_denied`/`t_corrupt` of `sel`, drop `t_valid`, go to RELEASE.
  - When the counter reaches `TIMEOUT` with no ready: drop `t_valid`, set denied=1 and corrupt=1, go to RELEASE.
- **RELEASE:** hold `t_valid`=0 for one cycle so the target returns to idle, then go to RESPOND.
- **RESPOND:** drive captured data and flags onto `bus_rdata`/`bus_denied`/`bus_corrupt`, pulse `bus_ready` for 1 cycle, go to WAIT.
- **WAIT:** hold the response fields while `bus_valid` is high. When `bus_valid` is low, zero `bus_rdata`/`bus_denied`/`bus_corrupt` and go to IDLE.
- `t_ready` bits are ignored outside DRIVE, and from non-selected targets. A late ready after a timeout has no effect.
- `bus_valid` changing during DRIVE/RELEASE/RESPOND is ignored; the latched request is authoritative.
- `t_*` broadcast fields are zero whenever no `t_valid` bit is set.

## Timing
- While `reset` is low: every output is 0 (`bus_ready`, `bus_rdata`, `bus_denied`, `bus_corrupt`, `t_valid`, all `t_*` fields), the FSM is in IDLE and the counter is 0. This applies immediately, even mid-transaction.
- Request sampled in IDLE at edge N:
  - `t_valid[sel]` is high after edge N+1.
  - Target ready sampled at edge M → `t_valid` low after M, `bus_ready` high after edge M+2.
- Decoder overhead is 3 cycles per transaction.
- Locally rejected request sampled at N: `bus_ready` is high after edge N+1, with no `t_valid` activity.
- Timeout: `t_valid` is high for exactly `TIMEOUT` cycles.
- The counter width is `$clog2(TIMEOUT+1)`; it is cleared on entry to DRIVE and does not wrap.
- Back-to-back transactions: a new request is sampled at the earliest on the cycle after WAIT sees `bus_valid` low.

## Structure
- Package `p_bus_pkg` holds:
  - the state enum `dec_state_t`;
  - the size encodings `SIZE_BYTE`..`SIZE_QUAD`;
  - a function `size_aligned(addr, size)`.
- Sub-module `p_bus_addr_match`: combinational priority matcher. It takes the address, `TARGET_BASE` and `TARGET_MASK`, and outputs `hit` and `sel` index. It is reused by future multi-initiator crossbars.

## Test plan
All scenarios use `TARGETS`=2, base0=0x1000_0000, base1=0x1000_1000, both masks 0xFFFF_F000, `TIMEOUT`=16.
- Word write to 0x1000_1004, wdata 0xA5A5_A5A5, wstrb 0xF → only `t_valid[1]` is asserted and `t_addr`/`t_wdata` match. The target model pulses ready; `bus_ready` is high 2 cycles later with denied=0.
- Byte read at 0x1000_0002; target 0 returns rdata 0x55 → `bus_rdata`=0x0000_0055, held until `bus_valid` drops, then 0.
- Read at 0x2000_0000 → `t_valid` stays 0; `bus_ready` is high after edge N+1 with denied=1, corrupt=0.
- Halfword write at 0x1000_0001, or size 3 with XLEN=32 → `t_valid` stays 0; denied=1.
- Target 0 never asserts ready → `t_valid[0]` is high for 16 cycles, then `bus_ready` with denied=1, corrupt=1. A `t_ready[0]` pulse injected during RELEASE is ignored.
- `reset` driven low during DRIVE → all outputs are 0 within the same cycle. After release, a fresh word read to target 1 completes normally.
